// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and the stall/flush/forward controls.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic [4:0]       rs1_e;
    logic [4:0]       rs2_e;
    logic [4:0]       rd_e;
    logic             load_e;
    logic             pc_src_e;
    logic [4:0]       rd_m;
    logic             reg_write_m;
    logic [4:0]       rd_w;
    logic             reg_write_w;
    logic             mem_req_m;
    logic             mem_ready;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic [1:0]       forward_a_e;
    logic [1:0]       forward_b_e;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;
    logic             mem_timeout;

    // Pipeline side: supplies hazard sources, consumes the controls
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
               rd_m, reg_write_m, rd_w, reg_write_w, mem_req_m, mem_ready,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               forward_a_e, forward_b_e, stall_cycles, flush_cycles, mem_timeout
    );

    // Hazard controller side
    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
               rd_m, reg_write_m, rd_w, reg_write_w, mem_req_m, mem_ready,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               forward_a_e, forward_b_e, stall_cycles, flush_cycles, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stalls, flushes,
// EX forwarding selects, a memory-wait FSM, saturating event counters and
// a sticky memory-timeout flag.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    localparam int WCNT_CLOG = $clog2(MEM_TIMEOUT + 1);
    localparam int WCNT_W    = (WCNT_CLOG > 8) ? WCNT_CLOG : 8;

    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;
    logic              timeout_q;
    logic              timeout_d;

    logic              memstall;
    logic              load_use;

    // MEM result wins over WB; x0 is never forwarded
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign memstall = hz.mem_req_m && !hz.mem_ready;
    assign load_use = hz.load_e && (hz.rd_e != 5'd0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic with the wait counter that runs alongside the FSM
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            RUN: begin
                if (memstall) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q != WCNT_MAX) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Output logic: memory stall > branch flush > load-use bubble, all forced off in reset.
    // A branch held in a frozen EX during a memory wait is flushed on the first free cycle
    // simply because memstall drops and the branch term then wins.
    always_comb begin
        hz.stall_f     = 1'b0;
        hz.stall_d     = 1'b0;
        hz.stall_e     = 1'b0;
        hz.stall_m     = 1'b0;
        hz.flush_d     = 1'b0;
        hz.flush_e     = 1'b0;
        hz.flush_w     = 1'b0;
        hz.forward_a_e = 2'b00;
        hz.forward_b_e = 2'b00;
        if (!reset) begin
            if (memstall) begin
                hz.stall_f = 1'b1;
                hz.stall_d = 1'b1;
                hz.stall_e = 1'b1;
                hz.stall_m = 1'b1;
                hz.flush_w = 1'b1;
            end else if (hz.pc_src_e) begin
                hz.flush_d = 1'b1;
                hz.flush_e = 1'b1;
            end else if (load_use) begin
                hz.stall_f = 1'b1;
                hz.stall_d = 1'b1;
                hz.flush_e = 1'b1;
            end
            hz.forward_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m,
                                     hz.rd_w, hz.reg_write_w);
            hz.forward_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m,
                                     hz.rd_w, hz.reg_write_w);
        end
    end

    // Next values for the saturating counters and the sticky timeout flag
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.stall_f && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hz.flush_d && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        timeout_d = timeout_q ||
                    ((state_q == MEM_WAIT) && (wcnt_q == WCNT_MAX) && !hz.mem_ready);
    end

    // Wait counter, event counters and timeout flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_cycles = flush_cnt_q;
    assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_ctrl;
    localparam int CNT_W  = 4;
    localparam int CNT_SAT = 15;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic       br;
        logic [4:0] rd_e;
        logic [4:0] rs1_d;
        logic [4:0] rs2_d;
        logic [4:0] rs1_e;
        logic [4:0] rs2_e;
        logic [4:0] rd_m;
        logic       wm;
        logic [4:0] rd_w;
        logic       ww;
        logic       req;
        logic       rdy;
        logic [3:0] st;   // {f,d,e,m}
        logic [2:0] fl;   // {d,e,w}
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   m_stall;
    int   m_flush;
    exp_t sb[$];
    vec_t tbl[20];

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif();

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string name, input logic rst, input logic ld, input logic br,
        input logic [4:0] rd_e, input logic [4:0] rs1_d, input logic [4:0] rs2_d,
        input logic [4:0] rs1_e, input logic [4:0] rs2_e,
        input logic [4:0] rd_m, input logic wm, input logic [4:0] rd_w, input logic ww,
        input logic req, input logic rdy,
        input logic [3:0] st, input logic [2:0] fl, input logic [1:0] fa, input logic [1:0] fb
    );
        vec_t v;
        v.name = name; v.rst = rst; v.ld = ld; v.br = br;
        v.rd_e = rd_e; v.rs1_d = rs1_d; v.rs2_d = rs2_d;
        v.rs1_e = rs1_e; v.rs2_e = rs2_e;
        v.rd_m = rd_m; v.wm = wm; v.rd_w = rd_w; v.ww = ww;
        v.req = req; v.rdy = rdy;
        v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then check registers after the edge
    task automatic step(input vec_t v, input logic exp_to);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset           = v.rst;
        hif.load_e      = v.ld;
        hif.pc_src_e    = v.br;
        hif.rd_e        = v.rd_e;
        hif.rs1_d       = v.rs1_d;
        hif.rs2_d       = v.rs2_d;
        hif.rs1_e       = v.rs1_e;
        hif.rs2_e       = v.rs2_e;
        hif.rd_m        = v.rd_m;
        hif.reg_write_m = v.wm;
        hif.rd_w        = v.rd_w;
        hif.reg_write_w = v.ww;
        hif.mem_req_m   = v.req;
        hif.mem_ready   = v.rdy;
        e.name = v.name; e.st = v.st; e.fl = v.fl; e.fa = v.fa; e.fb = v.fb;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            chk({v.name, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk({got.name, "/stall"}, {28'd0, hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m},
                {28'd0, got.st});
            chk({got.name, "/flush"}, {29'd0, hif.flush_d, hif.flush_e, hif.flush_w},
                {29'd0, got.fl});
            chk({got.name, "/fwd"}, {28'd0, hif.forward_a_e, hif.forward_b_e},
                {28'd0, got.fa, got.fb});
        end
        @(posedge clk);
        if (v.rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (v.st[3] && m_stall < CNT_SAT) m_stall++;
            if (v.fl[2] && m_flush < CNT_SAT) m_flush++;
        end
        #1;
        chk({v.name, "/stall_cycles"}, 32'(hif.stall_cycles), 32'(m_stall));
        chk({v.name, "/flush_cycles"}, 32'(hif.flush_cycles), 32'(m_flush));
        chk({v.name, "/mem_timeout"}, {31'd0, hif.mem_timeout}, {31'd0, exp_to});
    endtask

    vec_t idle;
    vec_t rst_v;
    vec_t wait_v;
    vec_t done_v;
    vec_t lu_v;
    vec_t br_v;

    initial begin
        n_pass = 0; n_total = 0; m_stall = 0; m_flush = 0;
        reset = 1'b1;
        hif.load_e = 0; hif.pc_src_e = 0; hif.rd_e = 0; hif.rs1_d = 0; hif.rs2_d = 0;
        hif.rs1_e = 0; hif.rs2_e = 0; hif.rd_m = 0; hif.reg_write_m = 0;
        hif.rd_w = 0; hif.reg_write_w = 0; hif.mem_req_m = 0; hif.mem_ready = 0;

        //            name            rst ld br rde rs1d rs2d rs1e rs2e rdm wm rdw ww req rdy st       fl      fa     fb
        idle   = mk("idle",           0, 0, 0, 0,  0,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b00);
        rst_v  = mk("reset_hold",     1, 1, 1, 5,  5,   0,   7,   7,   7,  1, 7,  1, 1,  0,  4'b0000, 3'b000, 2'b00, 2'b00);
        wait_v = mk("mem_wait",       0, 0, 0, 0,  0,   0,   0,   0,   0,  0, 0,  0, 1,  0,  4'b1111, 3'b001, 2'b00, 2'b00);
        done_v = mk("mem_done",       0, 0, 0, 0,  0,   0,   0,   0,   0,  0, 0,  0, 1,  1,  4'b0000, 3'b000, 2'b00, 2'b00);
        lu_v   = mk("sat_loaduse",    0, 1, 0, 5,  5,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b1100, 3'b010, 2'b00, 2'b00);
        br_v   = mk("sat_branch",     0, 0, 1, 0,  0,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b110, 2'b00, 2'b00);

        tbl[0]  = mk("idle",          0, 0, 0, 0,  0,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b00);
        tbl[1]  = mk("lu_rs1",        0, 1, 0, 5,  5,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b1100, 3'b010, 2'b00, 2'b00);
        tbl[2]  = mk("lu_rs2",        0, 1, 0, 9,  1,   9,   0,   0,   0,  0, 0,  0, 0,  0,  4'b1100, 3'b010, 2'b00, 2'b00);
        tbl[3]  = mk("lu_x0",         0, 1, 0, 0,  0,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b00);
        tbl[4]  = mk("lu_nomatch",    0, 1, 0, 5,  6,   7,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b00);
        tbl[5]  = mk("noload",        0, 0, 0, 5,  5,   5,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b00);
        tbl[6]  = mk("br_lu",         0, 1, 1, 5,  5,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b110, 2'b00, 2'b00);
        tbl[7]  = mk("br",            0, 0, 1, 0,  0,   0,   0,   0,   0,  0, 0,  0, 0,  0,  4'b0000, 3'b110, 2'b00, 2'b00);
        tbl[8]  = mk("fwd_mem_pri",   0, 0, 0, 0,  0,   0,   7,   0,   7,  1, 7,  1, 0,  0,  4'b0000, 3'b000, 2'b10, 2'b00);
        tbl[9]  = mk("fwd_wb",        0, 0, 0, 0,  0,   0,   7,   0,   0,  1, 7,  1, 0,  0,  4'b0000, 3'b000, 2'b01, 2'b00);
        tbl[10] = mk("fwd_b_wb",      0, 0, 0, 0,  0,   0,   0,   7,   7,  0, 7,  1, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b01);
        tbl[11] = mk("fwd_x0",        0, 0, 0, 0,  0,   0,   0,   0,   0,  1, 0,  1, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b00);
        tbl[12] = mk("fwd_mem_ab",    0, 0, 0, 0,  0,   0,   3,   3,   3,  1, 0,  0, 0,  0,  4'b0000, 3'b000, 2'b10, 2'b10);
        tbl[13] = mk("zero_wait",     0, 0, 0, 0,  0,   0,   0,   0,   0,  0, 0,  0, 1,  1,  4'b0000, 3'b000, 2'b00, 2'b00);
        tbl[14] = mk("mem_br_lu",     0, 1, 1, 5,  5,   0,   0,   0,   0,  0, 0,  0, 1,  0,  4'b1111, 3'b001, 2'b00, 2'b00);
        tbl[15] = mk("wait_done_br",  0, 1, 1, 5,  5,   0,   0,   0,   0,  0, 0,  0, 1,  1,  4'b0000, 3'b110, 2'b00, 2'b00);
        tbl[16] = mk("mem_fwd",       0, 0, 0, 0,  0,   0,   4,   0,   4,  1, 0,  0, 1,  0,  4'b1111, 3'b001, 2'b10, 2'b00);
        tbl[17] = mk("mem_fwd_done",  0, 0, 0, 0,  0,   0,   4,   0,   4,  1, 0,  0, 1,  1,  4'b0000, 3'b000, 2'b10, 2'b00);
        tbl[18] = mk("lu_and_fwd_wb", 0, 1, 0, 8,  0,   8,   8,   0,   0,  0, 8,  1, 0,  0,  4'b1100, 3'b010, 2'b01, 2'b00);
        tbl[19] = mk("fwd_wr_off",    0, 0, 0, 0,  0,   0,   6,   6,   6,  0, 6,  0, 0,  0,  4'b0000, 3'b000, 2'b00, 2'b00);

        // Reset holds every control low even with all hazards present
        step(rst_v, 1'b0);
        step(rst_v, 1'b0);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i], 1'b0);
        end

        // Three-cycle access: two stalled cycles then completion
        step(wait_v, 1'b0);
        step(wait_v, 1'b0);
        step(done_v, 1'b0);
        step(idle, 1'b0);

        // Counter saturation at 15
        for (int i = 0; i < 20; i++) step(lu_v, 1'b0);
        for (int i = 0; i < 20; i++) step(br_v, 1'b0);
        step(rst_v, 1'b0);

        // Timeout: sets after the 4th MEM_WAIT cycle, is sticky, only reset clears it
        for (int i = 0; i < 10; i++) step(wait_v, (i >= 4) ? 1'b1 : 1'b0);
        step(done_v, 1'b1);
        step(idle, 1'b1);
        step(rst_v, 1'b0);
        step(idle, 1'b0);

        // Reset mid-wait restarts the wait count; pending request re-enters MEM_WAIT
        for (int i = 0; i < 3; i++) step(wait_v, 1'b0);
        step(rst_v, 1'b0);
        for (int i = 0; i < 5; i++) step(wait_v, (i == 4) ? 1'b1 : 1'b0);
        step(done_v, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
